// File: rtl/ripple_count_checker.sv
// Self-check monitor for a ripple counter: re-times the Q bus, verifies each sample is one
// step from the last (mod 2^W), and reports lock, wrap and error status.
module ripple_count_checker #(
  parameter int unsigned W           = 4,
  parameter bit          DIR         = 1'b0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     q_in,
  input  logic             clear,
  output logic             locked,
  output logic             mismatch,
  output logic             wrap,
  output logic [W-1:0]     expected,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky
);

  localparam int unsigned FillW   = $clog2(SYNC_STAGES + 1);
  localparam int unsigned GoodW   = $clog2(LOCK_COUNT + 1);
  localparam logic [W-1:0] One    = W'(1);
  // Value whose correct arrival marks the terminal->start rollover of the counter.
  localparam logic [W-1:0] TermVal = DIR ? {W{1'b1}} : '0;

  typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

  logic [W-1:0]     sync_q [SYNC_STAGES];
  logic [W-1:0]     s, step_s;
  state_e           state_q, state_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [GoodW-1:0] good_q, good_d;
  logic [W-1:0]     expected_q, expected_d;
  logic             locked_q, locked_d;
  logic             mismatch_q, mismatch_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sticky_q, err_sticky_d;
  logic             hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= q_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign step_s = DIR ? (s - One) : (s + One);
  assign hit    = (s == expected_q);

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    good_d       = good_q;
    expected_d   = expected_q;
    locked_d     = locked_q;
    mismatch_d   = 1'b0;
    wrap_d       = 1'b0;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;

    unique case (state_q)
      StIdle: begin
        // s only carries real samples once the pipeline has filled.
        if (fill_q == FillW'(SYNC_STAGES)) begin
          expected_d = step_s;
          good_d     = '0;
          state_d    = StAcquire;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end
      StAcquire: begin
        expected_d = step_s;
        if (!hit) begin
          good_d = '0;
        end else if (good_q == GoodW'(LOCK_COUNT - 1)) begin
          good_d   = GoodW'(LOCK_COUNT);
          locked_d = 1'b1;
          state_d  = StLocked;
        end else begin
          good_d = good_q + 1'b1;
        end
      end
      StLocked: begin
        expected_d = step_s;
        if (hit) begin
          wrap_d = (s == TermVal);
        end else begin
          mismatch_d   = 1'b1;
          locked_d     = 1'b0;
          good_d       = '0;
          state_d      = StAcquire;
          err_sticky_d = 1'b1;
          if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clear) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      fill_q       <= '0;
      good_q       <= '0;
      expected_q   <= '0;
      locked_q     <= 1'b0;
      mismatch_q   <= 1'b0;
      wrap_q       <= 1'b0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      good_q       <= good_d;
      expected_q   <= expected_d;
      locked_q     <= locked_d;
      mismatch_q   <= mismatch_d;
      wrap_q       <= wrap_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign locked     = locked_q;
  assign mismatch   = mismatch_q;
  assign wrap       = wrap_q;
  assign expected   = expected_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule
